md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler that owns the HI/LO registers for the 5-stage pipeline.
- Accepts mult/div/mthi/mtlo issued from EX, runs multi-cycle ops against a latency counter, and commits results to HI/LO on completion.
- Raises a stall request toward ID whenever the decoding instruction touches HI/LO or the MDU while an operation is in flight.

---
 rtl/md_sched.sv | 131 +++++++++++++
 tb/tb_md_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler owning HI/LO; results commit after a fixed latency.
// Optional MD_MADD_EN decodes the madd/maddu/msub/msubu accumulate family (md_op 6-9).
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        id_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned CNT_W = 5;
    localparam int unsigned DW    = 32;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DW-1:0]      hi_q, lo_q;
    logic [2*DW-1:0]    pend;
    logic               pend_wr;

    logic op_mul_s, op_mul_u, op_div_s, op_div_u, op_mthi, op_mtlo;
    logic op_macc, macc_signed, macc_sub;

    // Opcode decode; accumulate codes only exist when the option is built in.
    always_comb begin
        op_mul_s    = 1'b0;
        op_mul_u    = 1'b0;
        op_div_s    = 1'b0;
        op_div_u    = 1'b0;
        op_mthi     = 1'b0;
        op_mtlo     = 1'b0;
        op_macc     = 1'b0;
        macc_signed = 1'b0;
        macc_sub    = 1'b0;
        case (md_op)
            4'd0: op_mul_s = 1'b1;
            4'd1: op_mul_u = 1'b1;
            4'd2: op_div_s = 1'b1;
            4'd3: op_div_u = 1'b1;
            4'd4: op_mthi  = 1'b1;
            4'd5: op_mtlo  = 1'b1;
`ifdef MD_MADD_EN
            4'd6: begin op_macc = 1'b1; macc_signed = 1'b1; end
            4'd7: begin op_macc = 1'b1; end
            4'd8: begin op_macc = 1'b1; macc_signed = 1'b1; macc_sub = 1'b1; end
            4'd9: begin op_macc = 1'b1; macc_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic            op_div, start_md, mul_signed;
    logic [2*DW-1:0] a_ext, b_ext, prod, acc, res;

    assign op_div     = op_div_s | op_div_u;
    assign start_md   = start & (op_mul_s | op_mul_u | op_div | op_macc);
    assign mul_signed = op_mul_s | (op_macc & macc_signed);

    // Low 64 bits of an extended product are the exact signed/unsigned 32x32 product.
    assign a_ext = mul_signed ? {{DW{rs[DW-1]}}, rs} : {{DW{1'b0}}, rs};
    assign b_ext = mul_signed ? {{DW{rt[DW-1]}}, rt} : {{DW{1'b0}}, rt};
    assign prod  = a_ext * b_ext;
    assign acc   = macc_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);

    logic          a_neg, b_neg, div_zero;
    logic [DW-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
    assign a_neg    = op_div_s & rs[DW-1];
    assign b_neg    = op_div_s & rt[DW-1];
    assign a_mag    = a_neg ? -rs : rs;
    assign b_mag    = b_neg ? -rt : rt;
    assign div_zero = (rt == '0);
    assign q_mag    = div_zero ? '0 : a_mag / b_mag;
    assign r_mag    = div_zero ? '0 : a_mag % b_mag;
    assign quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem      = a_neg ? -r_mag : r_mag;

    assign res = op_div ? {rem, quo} : (op_macc ? acc : prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_md) begin
                        pend    <= res;
                        pend_wr <= ~(op_div & div_zero);
                        cnt     <= op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state   <= RUN;
                    end else if (start & op_mthi) begin
                        hi_q <= rs;
                    end else if (start & op_mtlo) begin
                        lo_q <= rs;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (pend_wr) {hi_q, lo_q} <= pend;
                        pend_wr <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign stall = id_md_use & (busy | start_md);
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed spec cases plus random ops against a HI/LO model.
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, id_md_use;
    logic [3:0]  md_op;
    logic [31:0] rs, rt;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rs(rs), .rt(rt),
        .id_md_use(id_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: applies one op to the HI/LO model and returns the expected busy length.
    function automatic int model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] u, acc;
        int          lat;
        lat = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        u   = {32'd0, a} * {32'd0, b};
        acc = {hi_m, lo_m};
        case (op)
            4'd0: begin {hi_m, lo_m} = 64'(sa * sb); lat = MC; end
            4'd1: begin {hi_m, lo_m} = u; lat = MC; end
            4'd2: begin
                if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
                lat = DC;
            end
            4'd3: begin
                if (b != 0) begin lo_m = a / b; hi_m = a % b; end
                lat = DC;
            end
            4'd4: hi_m = a;
            4'd5: lo_m = a;
`ifdef MD_MADD_EN
            4'd6: begin {hi_m, lo_m} = acc + 64'(sa * sb); lat = MC; end
            4'd7: begin {hi_m, lo_m} = acc + u; lat = MC; end
            4'd8: begin {hi_m, lo_m} = acc - 64'(sa * sb); lat = MC; end
            4'd9: begin {hi_m, lo_m} = acc - u; lat = MC; end
`endif
            default: ;
        endcase
        return lat;
    endfunction

    // Drives one start pulse; returns at the negedge following the issue edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; rs = a; rt = b;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Counts busy cycles from the current negedge, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int lat;
        reset = 1'b0; start = 1'b0; md_op = '0; rs = '0; rt = '0; id_md_use = 1'b0;
        hi_m = '0; lo_m = '0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        @(negedge clk) reset = 1'b1;
        issue(4'd4, 32'h1234_5678, 32'd0);
        lat = model_op(4'd4, 32'h1234_5678, 32'd0);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
        issue(4'd5, 32'hCAFE_0001, 32'd0);
        lat = model_op(4'd5, 32'hCAFE_0001, 32'd0);
        checks++; if (lo !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_lo got %h want cafe0001", lo); end
        // Abort a multiply mid-flight between clock edges.
        issue(4'd0, 32'd7, 32'd9);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        hi_m = '0; lo_m = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got %0b want 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL midrun_hilo got %h want 0", {hi, lo}); end
        @(negedge clk) reset = 1'b1;
        repeat (MC + 2) @(negedge clk);
        checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("FAIL post_abort got %h want 0", {busy, hi, lo}); end
    endtask

    task automatic test_mult;
        int n, lat;
        issue(4'd0, 32'hFFFF_FFFE, 32'd3);
        lat = model_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        checks++; if (n !== MC) begin errors++; $display("FAIL mult_busy got %0d want %0d", n, MC); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_res got %h want fffffffffffffffa", {hi, lo}); end
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        lat = model_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        checks++; if (n !== lat) begin errors++; $display("FAIL multu_busy got %0d want %0d", n, lat); end
        checks++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin errors++; $display("FAIL multu_res got %h want 00000002fffffffa", {hi, lo}); end
    endtask

    task automatic test_div;
        int n, lat;
        issue(4'd2, 32'hFFFF_FFF9, 32'd2);
        lat = model_op(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (n !== DC) begin errors++; $display("FAIL div_busy got %0d want %0d", n, DC); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_res got %h want fffffffffffffffd", {hi, lo}); end
        issue(4'd3, 32'd7, 32'd0);
        lat = model_op(4'd3, 32'd7, 32'd0);
        wait_idle(n);
        checks++; if (n !== DC) begin errors++; $display("FAIL divz_busy got %0d want %0d", n, DC); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divz_res got %h want fffffffffffffffd", {hi, lo}); end
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        lat = model_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h want 0000000080000000", {hi, lo}); end
    endtask

    task automatic test_stall;
        int n, lat, bad;
        @(negedge clk);
        id_md_use = 1'b1; start = 1'b1; md_op = 4'd4; rs = 32'h0BAD_F00D; rt = '0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_mthi got %0b want 0", stall); end
        @(posedge clk);
        lat = model_op(4'd4, 32'h0BAD_F00D, 32'd0);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; md_op = 4'd0; rs = 32'd11; rt = 32'd13;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start got %0b want 1", stall); end
        lat = model_op(4'd0, 32'd11, 32'd13);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n = 0; bad = 0;
        while (busy && n < 64) begin
            if (stall !== 1'b1) bad++;
            n++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_busy got %0d low cycles want 0", bad); end
        checks++; if (n !== lat) begin errors++; $display("FAIL stall_len got %0d want %0d", n, lat); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_fall got %0b want 0", stall); end
        checks++; if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL stall_res got %h want %h", {hi, lo}, {hi_m, lo_m}); end
        id_md_use = 1'b0;
        issue(4'd1, 32'd5, 32'd6);
        lat = model_op(4'd1, 32'd5, 32'd6);
        checks++; if ({busy, stall} !== 2'b10) begin errors++; $display("FAIL stall_nouse got %b want 10", {busy, stall}); end
        wait_idle(n);
    endtask

    task automatic test_ignored_start;
        int n, lat;
        issue(4'd0, 32'h0001_0000, 32'h0003_0000);
        lat = model_op(4'd0, 32'h0001_0000, 32'h0003_0000);
        @(negedge clk);
        start = 1'b1; md_op = 4'd2; rs = 32'd100; rt = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_idle(n);
        checks++; if (n + 2 !== lat) begin errors++; $display("FAIL ignored_len got %0d want %0d", n + 2, lat); end
        checks++; if ({hi, lo} !== 64'h0000_0003_0000_0000) begin errors++; $display("FAIL ignored_res got %h want 0000000300000000", {hi, lo}); end
    endtask

    task automatic test_madd;
        int n, lat;
        logic [63:0] want;
        int want_n;
        issue(4'd4, 32'd0, 32'd0);
        lat = model_op(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'hFFFF_FFFF, 32'd0);
        lat = model_op(4'd5, 32'hFFFF_FFFF, 32'd0);
        issue(4'd6, 32'd1, 32'd1);
        lat = model_op(4'd6, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        want = 64'h0000_0001_0000_0000; want_n = MC;
`else
        want = 64'h0000_0000_FFFF_FFFF; want_n = 0;
`endif
        wait_idle(n);
        checks++; if (n !== want_n) begin errors++; $display("FAIL madd_busy got %0d want %0d", n, want_n); end
        checks++; if ({hi, lo} !== want) begin errors++; $display("FAIL madd_res got %h want %h", {hi, lo}, want); end
    endtask

    task automatic test_random;
        int n, lat, pick;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0) b = 32'd0;
            if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (pick == 2) b = 32'($urandom_range(1, 9));
            lat = model_op(op, a, b);
            issue(op, a, b);
            wait_idle(n);
            checks++; if (n !== lat) begin errors++; $display("FAIL rand_busy[%0d] op %0d got %0d want %0d", i, op, n, lat); end
            checks++; if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL rand_res[%0d] op %0d a %h b %h got %h want %h", i, op, a, b, {hi, lo}, {hi_m, lo_m}); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_ignored_start();
        test_madd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
